// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: soft-reset handshake, domain reset outputs and watchdog strobes.
// The sequencer uses the slave modport; the requester / consumer side uses master.
interface reset_sequencer_if;
    logic SW_RST_REQ;
    logic SW_RST_ACK;
    logic MEM_RST_N;
    logic DP_RST_N;
    logic CTRL_RST_N;
    logic READY;
    logic WDT_KICK;
    logic WDT_FIRED;

    modport slave (
        input  SW_RST_REQ,
        input  WDT_KICK,
        output SW_RST_ACK,
        output MEM_RST_N,
        output DP_RST_N,
        output CTRL_RST_N,
        output READY,
        output WDT_FIRED
    );

    modport master (
        output SW_RST_REQ,
        output WDT_KICK,
        input  SW_RST_ACK,
        input  MEM_RST_N,
        input  DP_RST_N,
        input  CTRL_RST_N,
        input  READY,
        input  WDT_FIRED
    );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches the synchronized CPU reset, then releases the memory, datapath
// and controller reset domains in order with programmable gaps and raises READY.
// A soft-reset request accepted in RUN reruns the whole sequence.
// Optional watchdog enabled by defining RSTSEQ_WDT_EN; without it WDT_KICK is ignored and
// WDT_FIRED is tied low.
module reset_sequencer #(
    parameter int unsigned STRETCH   = 16,
    parameter int unsigned GAP       = 4,
    parameter int unsigned CW        = 8,
    parameter int unsigned WDT_LIMIT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    reset_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        StHold,
        StRelMem,
        StRelDp,
        StRun
    } state_e;

    localparam logic [CW-1:0] StretchLast = CW'(STRETCH - 1);
    localparam logic [CW-1:0] GapLast     = CW'(GAP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_q, mem_d;
    logic          dp_q, dp_d;
    logic          ctrl_q, ctrl_d;
    logic          ready_q, ready_d;
    logic          ack_q, ack_d;
    logic          fired_q, fired_d;

`ifdef RSTSEQ_WDT_EN
    localparam logic [CW-1:0] WdtLast = CW'(WDT_LIMIT - 1);
`else
    // Watchdog absent: kick strobe and limit are deliberately unused.
    logic unused_wdt;
    assign unused_wdt = bus.WDT_KICK ^ (WDT_LIMIT == 0);
`endif

    // State register; RST low clears everything at once, independent of CLK.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StHold;
            cnt_q   <= '0;
            mem_q   <= 1'b0;
            dp_q    <= 1'b0;
            ctrl_q  <= 1'b0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            dp_q    <= dp_d;
            ctrl_q  <= ctrl_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            fired_q <= fired_d;
        end
    end

    // Next-state: counted release steps; in RUN the counter doubles as the watchdog timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        dp_d    = dp_q;
        ctrl_d  = ctrl_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        fired_d = 1'b0;

        unique case (state_q)
            StHold: begin
                if (cnt_q == StretchLast) begin
                    cnt_d   = '0;
                    mem_d   = 1'b1;
                    state_d = StRelMem;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRelMem: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    dp_d    = 1'b1;
                    state_d = StRelDp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRelDp: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    ctrl_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRun: begin
                // Soft request has priority over a same-edge watchdog timeout.
                if (bus.SW_RST_REQ) begin
                    ack_d   = 1'b1;
                    mem_d   = 1'b0;
                    dp_d    = 1'b0;
                    ctrl_d  = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StHold;
                end
`ifdef RSTSEQ_WDT_EN
                else if (bus.WDT_KICK) begin
                    cnt_d = '0;
                end else if (cnt_q == WdtLast) begin
                    fired_d = 1'b1;
                    mem_d   = 1'b0;
                    dp_d    = 1'b0;
                    ctrl_d  = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.MEM_RST_N  = mem_q;
    assign bus.DP_RST_N   = dp_q;
    assign bus.CTRL_RST_N = ctrl_q;
    assign bus.READY      = ready_q;
    assign bus.SW_RST_ACK = ack_q;
`ifdef RSTSEQ_WDT_EN
    assign bus.WDT_FIRED  = fired_q;
`else
    assign bus.WDT_FIRED  = 1'b0;
    logic unused_fired;
    assign unused_fired = fired_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default-timing instance plus a STRETCH=1/GAP=1 instance.
// Status byte layout: [5]=SW_RST_ACK [4]=WDT_FIRED [3]=MEM [2]=DP [1]=CTRL [0]=READY.
module tb_reset_sequencer;

    localparam int unsigned WdtLimit = 10;

    logic CLK = 1'b0;
    logic rst_main;
    logic rst_small;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;

    reset_sequencer_if bus_main ();
    reset_sequencer_if bus_small ();

    reset_sequencer #(
        .STRETCH   (16),
        .GAP       (4),
        .CW        (8),
        .WDT_LIMIT (WdtLimit)
    ) u_dut (
        .CLK (CLK),
        .RST (rst_main),
        .bus (bus_main)
    );

    reset_sequencer #(
        .STRETCH   (1),
        .GAP       (1),
        .CW        (8),
        .WDT_LIMIT (255)
    ) u_small (
        .CLK (CLK),
        .RST (rst_small),
        .bus (bus_small)
    );

    function automatic logic [7:0] status_main();
        return {2'b00, bus_main.SW_RST_ACK, bus_main.WDT_FIRED, bus_main.MEM_RST_N,
                bus_main.DP_RST_N, bus_main.CTRL_RST_N, bus_main.READY};
    endfunction

    function automatic logic [7:0] status_small();
        return {2'b00, bus_small.SW_RST_ACK, bus_small.WDT_FIRED, bus_small.MEM_RST_N,
                bus_small.DP_RST_N, bus_small.CTRL_RST_N, bus_small.READY};
    endfunction

    // Expected status e edges into a release sequence, no ack/fire.
    function automatic logic [7:0] exp_seq(input int e, input int m, input int d, input int c);
        return {4'b0000, (e >= m), (e >= d), (e >= c), (e >= c)};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic seq_check(input string tag, input int e);
        tick();
        check($sformatf("%s_e%0d", tag, e), status_main(), exp_seq(e, 16, 20, 24));
    endtask

    initial begin
        rst_main             = 1'b0;
        rst_small            = 1'b0;
        bus_main.SW_RST_REQ  = 1'b0;
        bus_main.WDT_KICK    = 1'b1;
        bus_small.SW_RST_REQ = 1'b0;
        bus_small.WDT_KICK   = 1'b1;

        // Reset state
        repeat (3) tick();
        check("reset_main", status_main(), 8'h00);
        check("reset_small", status_small(), 8'h00);

        // Hardware release: 16/20/24
        rst_main = 1'b1;
        for (int e = 1; e <= 24; e++) seq_check("hw_rel", e);

        // Soft reset from RUN
        bus_main.SW_RST_REQ = 1'b1;
        tick();
        check("sw_accept", status_main(), 8'h20);
        bus_main.SW_RST_REQ = 1'b0;
        for (int e = 1; e <= 24; e++) seq_check("sw_rel", e);

        // Request during HOLD is ignored
        bus_main.SW_RST_REQ = 1'b1;
        tick();
        check("sw_accept2", status_main(), 8'h20);
        bus_main.SW_RST_REQ = 1'b0;
        for (int e = 1; e <= 4; e++) seq_check("hold_req", e);
        bus_main.SW_RST_REQ = 1'b1;
        seq_check("hold_req", 5);
        bus_main.SW_RST_REQ = 1'b0;
        for (int e = 6; e <= 24; e++) seq_check("hold_req", e);

        // Asynchronous reset mid-cycle while in REL_MEM
        rst_main = 1'b0;
        repeat (2) tick();
        check("rerst", status_main(), 8'h00);
        rst_main = 1'b1;
        for (int e = 1; e <= 18; e++) seq_check("pre_async", e);
        #3;
        rst_main = 1'b0;
        #1;
        check("async_drop", status_main(), 8'h00);
        repeat (2) tick();
        rst_main = 1'b1;
        for (int e = 1; e <= 24; e++) seq_check("post_async", e);

        // Minimum timing instance
        rst_small = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("small_e%0d", e), status_small(), exp_seq(e, 1, 2, 3));
        end

`ifdef RSTSEQ_WDT_EN
        // Timeout after WdtLimit unkicked RUN edges
        bus_main.WDT_KICK = 1'b0;
        for (int k = 1; k < int'(WdtLimit); k++) begin
            tick();
            check($sformatf("wdt_wait_%0d", k), status_main(), 8'h0F);
        end
        tick();
        check("wdt_fire", status_main(), 8'h10);
        bus_main.WDT_KICK = 1'b1;
        for (int e = 1; e <= 24; e++) seq_check("wdt_rel", e);

        // Kick every 9 RUN edges: never fires
        for (int k = 1; k <= 40; k++) begin
            bus_main.WDT_KICK = (k % 9 == 0);
            tick();
            check($sformatf("wdt_kick_%0d", k), status_main(), 8'h0F);
        end
        // Last kick at RUN edge 36; timeout would land on edge 46
        bus_main.WDT_KICK = 1'b0;
        repeat (5) tick();
        check("wdt_pre_tie", status_main(), 8'h0F);
        bus_main.SW_RST_REQ = 1'b1;
        tick();
        check("wdt_tie_ack", status_main(), 8'h20);
        bus_main.SW_RST_REQ = 1'b0;
        bus_main.WDT_KICK   = 1'b1;
        seq_check("wdt_tie_after", 1);
`else
        // No watchdog: RUN persists with no kicks, WDT_FIRED stays low
        bus_main.WDT_KICK = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("no_wdt_%0d", k), status_main(), 8'h0F);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the CPU's asynchronous-assert/synchronous-deassert reset synchronizer and consumes its synchronized reset.
- Stretches that reset, then releases the memory, datapath and controller reset domains in a fixed order with programmable gaps, and asserts READY when the RISC core may fetch.
- Also accepts a software-reset request handshake that re-runs the whole sequence without touching the external reset.

Parameters:
STRETCH, 16, cycles held in HOLD after RST release before the memory domain is released (1..256)
GAP, 4, cycles between successive domain releases (1..256)
CW, 8, width of the internal cycle counter; must hold max(STRETCH, GAP, WDT_LIMIT)-1
WDT_LIMIT, 255, watchdog timeout in cycles (used only with RSTSEQ_WDT_EN; 1..2^CW)

Ports:
CLK  input  1  system clock, all state changes on the rising edge
RST  input  1  reset, asynchronous assert, active-low (driven by the synchronizer output)
SW_RST_REQ  input  1  level request for a soft reset
SW_RST_ACK  output  1  one-cycle pulse: soft request accepted
MEM_RST_N  output  1  memory-domain reset, active-low
DP_RST_N  output  1  datapath-domain reset, active-low
CTRL_RST_N  output  1  controller-domain reset, active-low
READY  output  1  core released and running
WDT_KICK  input  1  watchdog service strobe (ignored without RSTSEQ_WDT_EN)
WDT_FIRED  output  1  one-cycle pulse on watchdog timeout (constant 0 without RSTSEQ_WDT_EN)

Behaviour:
- Reset (RST=0):
  - Takes effect immediately, independent of CLK.
  - state=HOLD, cnt=0.
  - MEM_RST_N, DP_RST_N, CTRL_RST_N, READY, SW_RST_ACK and WDT_FIRED are all 0.
- Edge numbering: edge 1 is the first rising CLK edge that samples RST=1.
- States: HOLD -> REL_MEM -> REL_DP -> RUN.
- HOLD:
  - cnt increments each edge.
  - On the edge where cnt==STRETCH-1: cnt<=0, MEM_RST_N<=1, go to REL_MEM.
  - MEM_RST_N therefore rises at edge STRETCH.
- REL_MEM:
  - On the edge where cnt==GAP-1: cnt<=0, DP_RST_N<=1, go to REL_DP.
  - DP_RST_N rises at edge STRETCH+GAP.
- REL_DP:
  - On the edge where cnt==GAP-1: cnt<=0, CTRL_RST_N<=1 and READY<=1 on the same edge, go to RUN.
  - Both rise at edge STRETCH+2*GAP.
- RUN:
  - All three domain resets and READY stay 1.
  - If SW_RST_REQ=1 is sampled: on that edge SW_RST_ACK<=1 for exactly one cycle, all three domain resets and READY<=0, cnt<=0, go to HOLD.
  - The release sequence then repeats with the same timing, counted from the edge after acceptance.
- Ordering:
  - Releases are strictly MEM before DP before CTRL.
  - All domain assertions (hardware reset or soft reset) happen together.
- SW_RST_REQ:
  - Sampled only in RUN; ignored in HOLD/REL_MEM/REL_DP, with no ACK and no queuing.
  - A request still high on return to RUN is accepted again on the first RUN edge; requesters must drop REQ after seeing ACK.
- Reset mid-operation: RST low in any state clears all state and outputs immediately. The sequence restarts from edge 1 after release.
- Counter: never wraps. It is cleared on every state transition, and compares use cnt==N-1.

Optional Feature:
- Macro RSTSEQ_WDT_EN.
- Defined:
  - A watchdog counter runs only in RUN and is cleared on entry to RUN and on any edge sampling WDT_KICK=1.
  - If WDT_LIMIT consecutive RUN edges pass without a kick: WDT_FIRED pulses for one cycle and the block behaves exactly as an accepted soft reset (domain resets and READY low, go to HOLD), except that SW_RST_ACK stays 0.
  - If SW_RST_REQ and the timeout occur on the same edge, the soft request wins: ACK=1, WDT_FIRED=0.
- Not defined:
  - No watchdog logic.
  - WDT_KICK is ignored and WDT_FIRED is tied to 0.

Test Plan:
- Defaults; hold RST=0 for 3 cycles, then release -> MEM_RST_N rises at edge 16, DP_RST_N at 20, CTRL_RST_N and READY at 24. All outputs are 0 before edge 16.
- In RUN, raise SW_RST_REQ for 1 cycle -> next edge SW_RST_ACK=1 for 1 cycle and all resets/READY=0. MEM/DP/CTRL then rise 16/20/24 edges after acceptance.
- Pulse SW_RST_REQ during HOLD (edge 5) -> no ACK, and release timing stays 16/20/24.
- Drop RST asynchronously mid-cycle at edge 18 (in REL_MEM) -> MEM_RST_N=0 immediately without a clock. After re-release, full timing restarts at 16/20/24.
- STRETCH=1, GAP=1 -> MEM at edge 1, DP at edge 2, CTRL/READY at edge 3.
- With RSTSEQ_WDT_EN, WDT_LIMIT=10:
  - No kick for 10 RUN edges -> WDT_FIRED pulses, resets drop and the sequence reruns.
  - Kicking every 9 cycles -> WDT_FIRED never asserts.
  - Same-edge SW_RST_REQ and timeout -> ACK=1, WDT_FIRED=0.
